queue_ctrl: RTL and testbench
=============================

# queue_ctrl

FIFO queue controller sitting directly upstream of the 16×8 distributed RAM (single address port, synchronous write, asynchronous read on `spo`). It turns enqueue/dequeue requests into RAM write/read cycles, keeps head/tail pointers and an occupancy count, and registers the dequeued byte for downstream display logic. One RAM access per cycle; dequeue has priority over enqueue.

## Interface
- `DW`, default 8: data width; must match the RAM data width.
- `AW`, default 4: pointer width; depth = 2^AW = 16 entries.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enq`  in  1  enqueue request.
- `in`  in  DW  data to enqueue; sampled in the grant cycle.
- `deq`  in  1  dequeue request.
- `out`  out  DW  last dequeued byte, registered.
- `enq_ack`  out  1  one-cycle pulse, registered, the cycle after an enqueue grant.
- `deq_ack`  out  1  one-cycle pulse, registered, the cycle after a dequeue grant; `out` is valid from this cycle.
- `err`  out  1  registered pulse for a discarded request (enqueue when full, or dequeue when empty).
- `full`  out  1  count == 2^AW.
- `emp`  out  1  count == 0.
- `count`  out  AW+1  current occupancy, 0..16.
- `ram_a`  out  AW  RAM address; combinational.
- `ram_d`  out  DW  RAM write data; combinational, equals `in`.
- `ram_we`  out  1  RAM write enable; combinational, high only in an enqueue grant cycle.
- `ram_spo`  in  DW  RAM asynchronous read data.

## Operation
- State: `head`, `tail` (AW bits, wrap modulo 2^AW), `count` (AW+1 bits).
- Request sources `req_enq` and `req_deq` are set by the configuration below.
- Arbitration, evaluated every cycle:
  - `req_deq` and not `emp`: dequeue grant.
    - `ram_a = head`; `out <= ram_spo`.
    - `head <= head+1`; `count <= count-1`.
  - Else `req_enq` and not `full`: enqueue grant.
    - `ram_a = tail`, `ram_we = 1`, `ram_d = in`.
    - `tail <= tail+1`; `count <= count+1`.
  - Else: `ram_we = 0`, `ram_a = head`.
- Discarded requests:
  - `req_deq` while `emp`, or `req_enq` while `full` (and not shadowed by a dequeue grant), sets `err <= 1` for one cycle.
  - No pointer, count or `out` change.
- Simultaneous valid enqueue and dequeue: the dequeue is granted. The enqueue is not lost; it stays requested and is evaluated again next cycle.
- `count` never leaves the range 0..16. `full` and `emp` are derived from `count`, never from pointer equality.

## Timing
- Reset (synchronous `rst` high at an edge):
  - `head = tail = 0`, `count = 0`, `out = 0`.
  - `enq_ack = deq_ack = err = 0`; pending flags cleared.
  - `emp = 1`, `full = 0`.
  - `ram_we` is forced 0 while `rst` is high. Reset mid-operation drops any in-flight request; RAM contents are not cleared.
- Latency:
  - Grant cycle N: RAM write happens at edge N.
  - Ack, `count` and `out` are updated after edge N, visible in cycle N+1.
- Back-to-back operations are allowed on every cycle.

## Configuration
- `QUEUE_EDGE_DETECT_EN` defined (button-driven board use):
  - `enq`/`deq` are level inputs; a rising edge sets a pending flag.
  - `req_* = pending flag`; the flag clears on grant or on discard.
  - One operation per rising edge, however long the level is held.
- Undefined (handshake mode):
  - `req_enq = enq`, `req_deq = deq`.
  - The requester holds the request until it sees the ack, then deasserts it in the ack cycle.
  - A request held while full or empty pulses `err` every such cycle.

## Structure
- Package `queue_pkg`: `DW`, `AW` and `DEPTH` defaults.
- Sub-module `edge_pulse`: rising-edge detector with a registered previous value, reset to 0. Instantiated twice, only under `QUEUE_EDGE_DETECT_EN`.
- The RAM itself is not instantiated here; the top level connects `ram_*` to it.

## Test plan
- Reset, then enqueue 0x23, 0xf1, 0x90 → RAM writes at a=0,1,2; three `enq_ack` pulses; `count=3`; `emp=0`.
- Dequeue three times → `out` = 0x23, 0xf1, 0x90 in order, each valid with `deq_ack`; `count=0`; `emp=1`.
- Dequeue when empty → `err` pulses one cycle; `out` holds 0x90; pointers unchanged.
- Enqueue 16 bytes → `full=1`, `count=16`. A 17th enqueue → `err` pulse, `ram_we` stays 0, `count=16`.
- `count=2`, assert `enq` and `deq` together (handshake mode) → dequeue in cycle N (`count=1`), enqueue granted in N+1 (`count=2`).
- Run 20 interleaved enqueue/dequeue pairs so `head` and `tail` wrap 15→0 → FIFO order preserved. Then assert `rst` with `count=5` → `count=0`, `out=0`, `emp=1` the next cycle.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared defaults and types for the queue controller.
// Build option: QUEUE_EDGE_DETECT_EN selects edge-detected request inputs.
package queue_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    // Outcome of the per-cycle arbitration between dequeue and enqueue.
    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_DEQ  = 2'd1,
        GNT_ENQ  = 2'd2
    } gnt_e;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse when the level goes from 0 to 1.
// Used only when QUEUE_EDGE_DETECT_EN is defined.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev_r;

    // Remember last cycle's level so a 0->1 transition can be recognised.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level;
        end
    end

    assign pulse = level & ~prev_r;

endmodule

// File: rtl/queue_ctrl.sv
// FIFO controller in front of a single-port 16x8 distributed RAM
// (synchronous write, asynchronous read). Dequeue wins over enqueue.
// Build option: QUEUE_EDGE_DETECT_EN turns enq/deq into level inputs whose
// rising edges latch a pending request; otherwise enq/deq are handshake
// requests held until the matching ack.
module queue_ctrl #(
    parameter int DW = queue_pkg::DW,
    parameter int AW = queue_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  logic [DW-1:0] in,
    input  logic          deq,
    output logic [DW-1:0] out,
    output logic          enq_ack,
    output logic          deq_ack,
    output logic          err,
    output logic          full,
    output logic          emp,
    output logic [AW:0]   count,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_spo
);

    import queue_pkg::*;

    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW:0]   count_r;
    logic [DW-1:0] out_r;
    logic          enq_ack_r;
    logic          deq_ack_r;
    logic          err_r;

    logic          req_enq_s;
    logic          req_deq_s;
    gnt_e          gnt_s;
    logic          dis_enq_s;
    logic          dis_deq_s;

`ifdef QUEUE_EDGE_DETECT_EN
    logic rise_enq_s;
    logic rise_deq_s;
    logic pend_enq_r;
    logic pend_deq_r;

    edge_pulse u_enq_edge (
        .clk   (clk),
        .rst   (rst),
        .level (enq),
        .pulse (rise_enq_s)
    );

    edge_pulse u_deq_edge (
        .clk   (clk),
        .rst   (rst),
        .level (deq),
        .pulse (rise_deq_s)
    );

    // Pending flags: set by a rising edge, cleared once granted or discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_enq_r <= 1'b0;
            pend_deq_r <= 1'b0;
        end else begin
            pend_enq_r <= rise_enq_s | (pend_enq_r & ~((gnt_s == GNT_ENQ) | dis_enq_s));
            pend_deq_r <= rise_deq_s | (pend_deq_r & ~((gnt_s == GNT_DEQ) | dis_deq_s));
        end
    end

    assign req_enq_s = pend_enq_r;
    assign req_deq_s = pend_deq_r;
`else
    assign req_enq_s = enq;
    assign req_deq_s = deq;
`endif

    // Occupancy flags come from the counter only, so full and empty never alias.
    assign full = (count_r == FULL_CNT);
    assign emp  = (count_r == {(AW+1){1'b0}});

    // Arbitration: dequeue first, then enqueue; nothing is granted during reset.
    always_comb begin
        gnt_s = GNT_IDLE;
        if (rst) begin
            gnt_s = GNT_IDLE;
        end else if (req_deq_s && !emp) begin
            gnt_s = GNT_DEQ;
        end else if (req_enq_s && !full) begin
            gnt_s = GNT_ENQ;
        end else begin
            gnt_s = GNT_IDLE;
        end
    end

    // Discards: an enqueue behind a granted dequeue is deferred, not discarded.
    always_comb begin
        dis_enq_s = 1'b0;
        dis_deq_s = 1'b0;
        if (rst) begin
            dis_enq_s = 1'b0;
            dis_deq_s = 1'b0;
        end else begin
            dis_deq_s = req_deq_s & emp;
            dis_enq_s = req_enq_s & full & (gnt_s != GNT_DEQ);
        end
    end

    // RAM port: tail with write enable on an enqueue grant, otherwise head for reading.
    always_comb begin
        ram_a  = head_r;
        ram_we = 1'b0;
        case (gnt_s)
            GNT_ENQ: begin
                ram_a  = tail_r;
                ram_we = 1'b1;
            end
            GNT_DEQ: begin
                ram_a  = head_r;
                ram_we = 1'b0;
            end
            default: begin
                ram_a  = head_r;
                ram_we = 1'b0;
            end
        endcase
    end

    assign ram_d = in;

    // Pointer, count and output-data state updated on each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
            out_r   <= {DW{1'b0}};
        end else begin
            case (gnt_s)
                GNT_DEQ: begin
                    head_r  <= head_r + PTR_ONE;
                    count_r <= count_r - CNT_ONE;
                    out_r   <= ram_spo;
                end
                GNT_ENQ: begin
                    tail_r  <= tail_r + PTR_ONE;
                    count_r <= count_r + CNT_ONE;
                end
                default: begin
                    head_r  <= head_r;
                    tail_r  <= tail_r;
                    count_r <= count_r;
                    out_r   <= out_r;
                end
            endcase
        end
    end

    // One-cycle status pulses reporting last cycle's arbitration outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            enq_ack_r <= 1'b0;
            deq_ack_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            enq_ack_r <= (gnt_s == GNT_ENQ);
            deq_ack_r <= (gnt_s == GNT_DEQ);
            err_r     <= dis_enq_s | dis_deq_s;
        end
    end

    assign out     = out_r;
    assign enq_ack = enq_ack_r;
    assign deq_ack = deq_ack_r;
    assign err     = err_r;
    assign count   = count_r;

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed self-checking bench for queue_ctrl in handshake mode, with a
// behavioural 16x8 RAM and a byte scoreboard for FIFO ordering.
module tb_queue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq;
    logic [7:0] in;
    logic       deq;
    logic [7:0] out;
    logic       enq_ack;
    logic       deq_ack;
    logic       err;
    logic       full;
    logic       emp;
    logic [4:0] count;
    logic [3:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_we;
    logic [7:0] ram_spo;

    logic [7:0] mem [16];

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb [$];
    logic [3:0] m_head;
    logic [3:0] m_tail;
    int         m_count;
    logic [7:0] m_out;

    queue_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .enq     (enq),
        .in      (in),
        .deq     (deq),
        .out     (out),
        .enq_ack (enq_ack),
        .deq_ack (deq_ack),
        .err     (err),
        .full    (full),
        .emp     (emp),
        .count   (count),
        .ram_a   (ram_a),
        .ram_d   (ram_d),
        .ram_we  (ram_we),
        .ram_spo (ram_spo)
    );

    always #5 clk = ~clk;

    // Behavioural distributed RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
    end
    assign ram_spo = mem[ram_a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic enq_ok(input logic [7:0] d);
        enq = 1'b1;
        in  = d;
        @(negedge clk);
        chk("enq_we", {31'd0, ram_we}, 32'd1);
        chk("enq_addr", {28'd0, ram_a}, {28'd0, m_tail});
        @(posedge clk);
        #1;
        sb.push_back(d);
        m_tail  = m_tail + 4'd1;
        m_count = m_count + 1;
        chk("enq_ack", {31'd0, enq_ack}, 32'd1);
        chk("enq_count", {27'd0, count}, m_count);
        enq = 1'b0;
    endtask

    task automatic deq_ok();
        deq = 1'b1;
        @(negedge clk);
        chk("deq_addr", {28'd0, ram_a}, {28'd0, m_head});
        chk("deq_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        m_out   = sb.pop_front();
        m_head  = m_head + 4'd1;
        m_count = m_count - 1;
        chk("deq_ack", {31'd0, deq_ack}, 32'd1);
        chk("deq_out", {24'd0, out}, {24'd0, m_out});
        chk("deq_count", {27'd0, count}, m_count);
        deq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enq = 1'b1; in = 8'h55; deq = 1'b0;
        m_head = 4'd0; m_tail = 4'd0; m_count = 0; m_out = 8'h00;

        // Reset, with an enqueue held to show the write enable stays low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_emp", {31'd0, emp}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_acks", {29'd0, enq_ack, deq_ack, err}, 32'd0);
        enq = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three enqueues then three dequeues in order.
        enq_ok(8'h23);
        enq_ok(8'hf1);
        enq_ok(8'h90);
        chk("three_emp", {31'd0, emp}, 32'd0);
        deq_ok();
        deq_ok();
        deq_ok();
        chk("drain_emp", {31'd0, emp}, 32'd1);

        // Dequeue while empty: error pulse, nothing moves.
        deq = 1'b1;
        @(posedge clk);
        #1;
        chk("deq_err", {31'd0, err}, 32'd1);
        chk("deq_err_ack", {31'd0, deq_ack}, 32'd0);
        chk("deq_err_out", {24'd0, out}, 32'h90);
        deq = 1'b0;
        @(negedge clk);
        chk("idle_addr", {28'd0, ram_a}, {28'd0, m_head});
        @(posedge clk);
        #1;
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        chk("deq_err_count", {27'd0, count}, 32'd0);

        // Fill to 16, then a 17th enqueue is discarded.
        for (int i = 0; i < 16; i++) enq_ok(8'(8'h40 + i * 3));
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {27'd0, count}, 32'd16);
        enq = 1'b1;
        in  = 8'hee;
        @(negedge clk);
        chk("full_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        chk("full_err", {31'd0, err}, 32'd1);
        chk("full_ack", {31'd0, enq_ack}, 32'd0);
        chk("full_count", {27'd0, count}, 32'd16);
        enq = 1'b0;

        // Drain down to two entries.
        for (int i = 0; i < 14; i++) deq_ok();

        // Simultaneous request: dequeue first, the enqueue follows next cycle.
        enq = 1'b1;
        deq = 1'b1;
        in  = 8'h7c;
        @(negedge clk);
        chk("sim_we_first", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        m_out   = sb.pop_front();
        m_head  = m_head + 4'd1;
        m_count = m_count - 1;
        chk("sim_deq_ack", {31'd0, deq_ack}, 32'd1);
        chk("sim_enq_ack0", {31'd0, enq_ack}, 32'd0);
        chk("sim_count1", {27'd0, count}, 32'd1);
        chk("sim_out", {24'd0, out}, {24'd0, m_out});
        deq = 1'b0;
        @(negedge clk);
        chk("sim_we_second", {31'd0, ram_we}, 32'd1);
        chk("sim_addr", {28'd0, ram_a}, {28'd0, m_tail});
        @(posedge clk);
        #1;
        sb.push_back(8'h7c);
        m_tail  = m_tail + 4'd1;
        m_count = m_count + 1;
        chk("sim_enq_ack", {31'd0, enq_ack}, 32'd1);
        chk("sim_count2", {27'd0, count}, 32'd2);
        enq = 1'b0;

        // Interleaved pairs wrapping both pointers.
        for (int i = 0; i < 20; i++) begin
            enq_ok(8'($urandom_range(255, 0)));
            deq_ok();
        end

        // Reset mid-operation with five entries and a request in flight.
        for (int i = 0; i < 3; i++) enq_ok(8'(8'hc0 + i));
        chk("pre_rst_count", {27'd0, count}, 32'd5);
        rst = 1'b1;
        enq = 1'b1;
        in  = 8'h11;
        @(negedge clk);
        chk("mid_rst_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_out", {24'd0, out}, 32'd0);
        chk("mid_rst_emp", {31'd0, emp}, 32'd1);
        chk("mid_rst_ack", {31'd0, enq_ack}, 32'd0);
        rst = 1'b0;
        enq = 1'b0;
        sb.delete();
        m_head = 4'd0; m_tail = 4'd0; m_count = 0;

        // Pointers restart from zero after reset.
        enq_ok(8'ha5);
        deq_ok();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
